// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-bus loads/stores, stalls upstream while
// the bus is busy, and registers the write-back triple for the MEM/WB boundary.
module mem_stage #(
  parameter int RADDR_WIDTH = 5,
  parameter int RDATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
  input  logic [3:0]             mem_op_i,
  input  logic [RDATA_WIDTH-1:0] store_data_i,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [RDATA_WIDTH-1:0] bus_addr_o,
  output logic [RDATA_WIDTH-1:0] bus_wdata_o,
  output logic [3:0]             bus_be_o,
  input  logic                   bus_ack_i,
  input  logic [RDATA_WIDTH-1:0] bus_rdata_i,
  output logic                   stall_o,
  output logic                   misalign_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Decoded view of the incoming op
  logic                   dec_load;
  logic                   dec_store;
  logic                   dec_misalign;
  logic                   dec_start;
  logic [3:0]             dec_be;
  logic [RDATA_WIDTH-1:0] dec_wdata;
  logic [1:0]             addr_lo;

  // Transaction context held for the duration of a bus access
  logic [3:0]             op_q;
  logic [1:0]             off_q;
  logic [RADDR_WIDTH-1:0] waddr_q;
  logic                   we_q;
  logic [RDATA_WIDTH-1:0] wdata_q;
  logic                   load_q;

  logic                   stall_raw;
  logic [RDATA_WIDTH-1:0] load_result;

  assign addr_lo = reg_wdata_i[1:0];

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_load     = 1'b0;
    dec_store    = 1'b0;
    dec_misalign = 1'b0;
    dec_be       = 4'b1111;
    dec_wdata    = store_data_i;
    case (mem_op_i)
      OP_LB, OP_LBU: dec_load = 1'b1;
      OP_LH, OP_LHU: begin
        dec_load     = 1'b1;
        dec_misalign = addr_lo[0];
      end
      OP_LW: begin
        dec_load     = 1'b1;
        dec_misalign = |addr_lo;
      end
      OP_SB: begin
        dec_store = 1'b1;
        dec_be    = 4'b0001 << addr_lo;
        dec_wdata = {(RDATA_WIDTH/8){store_data_i[7:0]}};
      end
      OP_SH: begin
        dec_store    = 1'b1;
        dec_misalign = addr_lo[0];
        dec_be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        dec_wdata    = {(RDATA_WIDTH/16){store_data_i[15:0]}};
      end
      OP_SW: begin
        dec_store    = 1'b1;
        dec_misalign = |addr_lo;
      end
      default: ;
    endcase
    dec_start = (dec_load | dec_store) & ~dec_misalign;
  end

  // Lane extraction for the load that is completing; the held offset picks the lane.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b      = bus_rdata_i[{off_q, 3'b000} +: 8];
    lane_h      = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    load_result = bus_rdata_i;
    case (op_q)
      OP_LB:   load_result = {{(RDATA_WIDTH-8){lane_b[7]}}, lane_b};
      OP_LBU:  load_result = {{(RDATA_WIDTH-8){1'b0}}, lane_b};
      OP_LH:   load_result = {{(RDATA_WIDTH-16){lane_h[15]}}, lane_h};
      OP_LHU:  load_result = {{(RDATA_WIDTH-16){1'b0}}, lane_h};
      default: load_result = bus_rdata_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dec_start) begin
          state_d   = ST_BUS;
          stall_raw = 1'b1;
        end
      end
      ST_BUS: begin
        if (bus_ack_i) begin
          state_d = ST_IDLE;
        end else begin
          stall_raw = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset is asynchronous, so the stall must be masked directly rather than
  // waiting for the state register to settle.
  assign stall_o = stall_raw & ~rst_i;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_be_o    <= '0;
      misalign_o  <= 1'b0;
      reg_waddr_o <= '0;
      reg_we_o    <= 1'b0;
      reg_wdata_o <= '0;
      op_q        <= OP_NONE;
      off_q       <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      load_q      <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (dec_start) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= dec_store;
            bus_addr_o  <= {reg_wdata_i[RDATA_WIDTH-1:2], 2'b00};
            bus_wdata_o <= dec_wdata;
            bus_be_o    <= dec_be;
            op_q        <= mem_op_i;
            off_q       <= addr_lo;
            waddr_q     <= reg_waddr_i;
            we_q        <= reg_we_i;
            wdata_q     <= reg_wdata_i;
            load_q      <= dec_load;
            // Bubble into MEM/WB while the access is outstanding
            reg_we_o    <= 1'b0;
          end else begin
            reg_waddr_o <= reg_waddr_i;
            reg_we_o    <= reg_we_i & ~dec_misalign;
            reg_wdata_o <= reg_wdata_i;
            misalign_o  <= dec_misalign;
          end
        end
        ST_BUS: begin
          if (bus_ack_i) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_be_o    <= '0;
            reg_waddr_o <= waddr_q;
            reg_we_o    <= load_q & we_q;
            reg_wdata_o <= load_q ? load_result : wdata_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
